// File: rtl/smpl_pkg.sv
// smpl_pkg: shared definitions for the sample decimator.
//   mode_e      : MODE_PICK (point sample) / MODE_PEAK (window min/max)
//   CNT_W_DEF   : default decimation counter width
//   DATA_W_DEF  : default sample width
package smpl_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    MODE_PICK = 1'b0,
    MODE_PEAK = 1'b1
  } mode_e;

endpackage

// File: rtl/cntn.sv
// cntn: loadable down-counter.
//   clk  : clock, rising edge
//   nrst : asynchronous active-low reset, clears the count
//   en   : allow a step (load takes priority)
//   step : amount subtracted per enabled clock
//   load : load cin on the next edge
//   cin  : load value
//   cnt  : current count
module cntn #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic [W-1:0] step,
  input  logic         load,
  input  logic [W-1:0] cin,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = cin;
    end else if (en) begin
      cnt_d = cnt_q - step;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/smpl_deci_pk.sv
// smpl_deci_pk: sample decimator with optional peak (min/max) detection.
// A down-counter reloads num whenever en is low or the count reaches zero,
// so one window spans num+1 clocks and ends on the strobe cycle.
//   clk      : clock, rising edge
//   nrst     : asynchronous active-low reset
//   en       : enable; low discards the current window and idles
//   num      : decimation count, period = num+1 clocks
//   mode     : 0 = pick, 1 = peak (only with SMPL_DECI_PK_PEAK_EN)
//   div2     : out2 fires on every second out
//   din      : unsigned sample, valid every clock
//   out      : decimated strobe, one clock, one clock after window end
//   out2     : out, thinned to every second strobe when div2=1
//   dout_max : window maximum (pick: sample at window end)
//   dout_min : window minimum (pick: sample at window end)
// Build option: define SMPL_DECI_PK_PEAK_EN to implement peak mode; without
// it mode is ignored and no running min/max registers exist.
module smpl_deci_pk
  import smpl_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic [CNT_W-1:0]  num,
  input  logic              mode,
  input  logic              div2,
  input  logic [DATA_W-1:0] din,
  output logic              out,
  output logic              out2,
  output logic [DATA_W-1:0] dout_max,
  output logic [DATA_W-1:0] dout_min
);

  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero;
  logic              strb;
  logic              load;
  logic              out_q;
  logic              phase_q;
  logic [DATA_W-1:0] dout_max_q;
  logic [DATA_W-1:0] dout_min_q;
  logic [DATA_W-1:0] new_max;
  logic [DATA_W-1:0] new_min;

  assign cnt_zero = (cnt == '0);
  assign strb     = en & cnt_zero;
  // Reload while idle so the first window after en rises is a full one.
  assign load     = ~en | cnt_zero;

  cntn #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .nrst (nrst),
    .en   (en),
    .step ({{(CNT_W-1){1'b0}}, 1'b1}),
    .load (load),
    .cin  (num),
    .cnt  (cnt)
  );

`ifdef SMPL_DECI_PK_PEAK_EN
  logic [DATA_W-1:0] run_max_q, run_max_d;
  logic [DATA_W-1:0] run_min_q, run_min_d;
  logic [DATA_W-1:0] win_max;
  logic [DATA_W-1:0] win_min;
  logic              start_q;
  mode_e             mode_q;
  mode_e             mode_eff;

  // Mode is sampled in a window's first cycle and held until it ends.
  assign mode_eff = start_q ? mode_e'(mode) : mode_q;
  assign win_max  = (din > run_max_q) ? din : run_max_q;
  assign win_min  = (din < run_min_q) ? din : run_min_q;

  always_comb begin
    run_max_d = win_max;
    run_min_d = win_min;
    // Reseed at window end or while idle; next cycle's din wins outright.
    if (load) begin
      run_max_d = '0;
      run_min_d = '1;
    end
  end

  always_comb begin
    new_max = din;
    new_min = din;
    if (mode_eff == MODE_PEAK) begin
      new_max = win_max;
      new_min = win_min;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      run_max_q <= '0;
      run_min_q <= '1;
      start_q   <= 1'b1;
      mode_q    <= MODE_PICK;
    end else begin
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      start_q   <= load;
      mode_q    <= mode_eff;
    end
  end
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign new_max     = din;
  assign new_min     = din;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_q      <= 1'b0;
      phase_q    <= 1'b0;
      dout_max_q <= '0;
      dout_min_q <= '0;
    end else begin
      out_q   <= strb;
      phase_q <= en ? (phase_q ^ strb) : 1'b0;
      if (strb) begin
        dout_max_q <= new_max;
        dout_min_q <= new_min;
      end
    end
  end

  assign out      = out_q;
  // phase_q has already toggled for the strobe being presented on out.
  assign out2     = out_q & (~phase_q | ~div2);
  assign dout_max = dout_max_q;
  assign dout_min = dout_min_q;

endmodule
